if_prefetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the IF/ID boundary and drives it.
- Owns the PC register, the instruction memory `instr_mem` and a small prefetch queue.
- Outputs go straight into the decode stage.
- Honours the hazard-unit stall and the EX/MEM branch redirect (flush).

---
 rtl/if_prefetch_stage.sv | 159 +++++++++++++++
 tb/tb_if_prefetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction-fetch stage with PC, instruction memory and
// a small prefetch queue feeding the IF/ID boundary. Honours stall and the
// EX/MEM branch redirect (flush).
// Optional perf counters are compiled in when IF_PREFETCH_PERF_EN is defined;
// otherwise flush_count/stall_count are tied to zero.
module if_prefetch_stage #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] pc_if_id,
    output logic [31:0]     instruction_if_id,
    output logic            valid_if_id,
    output logic            inv_fetch_addr,
    output logic            misaligned_redirect,
    output logic [15:0]     flush_count,
    output logic [15:0]     stall_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Instruction memory; contents are loaded externally and never reset.
    logic [31:0] instr_mem [0:IMEM_WORDS-1];

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_pc_if_id;
    logic [31:0]      r_instr_if_id;
    logic             r_valid_if_id;
    logic             r_misaligned;

    logic [XLEN-1:0]  w_word_idx;
    logic             w_in_range;
    logic [31:0]      w_fetch_instr;
    logic             w_pop;
    logic             w_push;

    // Fetch address decode and combinational memory read.
    always_comb begin
        w_word_idx    = r_pc >> 2;
        w_in_range    = (w_word_idx < XLEN'(IMEM_WORDS));
        w_fetch_instr = instr_mem[w_word_idx[IDX_W-1:0]];
        w_pop         = !stall && !redirect && (r_count != '0);
        w_push        = !redirect && w_in_range &&
                        ((r_count < CNT_W'(DEPTH)) || w_pop);
    end

    // PC register: redirect reloads an aligned target, a push advances by 4.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    // Queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Queue payload storage; only valid entries are ever read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_pc;
            r_q_instr[r_tail] <= w_fetch_instr;
        end
    end

    // IF/ID output register: redirect bubbles, stall holds, else pop or bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc_if_id    <= '0;
            r_instr_if_id <= NOP;
            r_valid_if_id <= 1'b0;
        end else if (redirect) begin
            r_instr_if_id <= NOP;
            r_valid_if_id <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                r_pc_if_id    <= r_q_pc[r_head];
                r_instr_if_id <= r_q_instr[r_head];
                r_valid_if_id <= 1'b1;
            end else begin
                r_instr_if_id <= NOP;
                r_valid_if_id <= 1'b0;
            end
        end
    end

    // Sticky flag for a redirect target that was not word aligned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [15:0] r_flush_count;
    logic [15:0] r_stall_count;

    // Saturating flush and stall event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flush_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (redirect && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
            if (stall && !redirect && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign flush_count = r_flush_count;
    assign stall_count = r_stall_count;
`else
    assign flush_count = 16'h0000;
    assign stall_count = 16'h0000;
`endif

    assign PC                  = r_pc;
    assign pc_if_id            = r_pc_if_id;
    assign instruction_if_id   = r_instr_if_id;
    assign valid_if_id         = r_valid_if_id;
    assign inv_fetch_addr      = !w_in_range;
    assign misaligned_redirect = r_misaligned;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed, table-driven bench for if_prefetch_stage: a 64-word instance for
// fetch/stall/redirect/reset and a 4-word instance for the out-of-range case.
module tb_if_prefetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] M0  = 32'h0050_0093;
    localparam logic [31:0] M4  = 32'h00a0_0113;
    localparam logic [31:0] M8  = 32'h0020_81b3;
    localparam logic [31:0] MC  = 32'h0030_2023;
    localparam logic [31:0] M20 = 32'h1000_0008;
    localparam logic [31:0] M30 = 32'h1000_000C;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] pc, pc_if_id;
    logic [31:0] instr;
    logic        valid, inv, mis;
    logic [15:0] fcnt, scnt;

    logic        rst4;
    logic [63:0] pc4, pc_if_id4;
    logic [31:0] instr4;
    logic        valid4, inv4, mis4;
    logic [15:0] fcnt4, scnt4;
    logic        stall4, redirect4;
    logic [63:0] redirect_pc4;

    int checks = 0;
    int errors = 0;

    if_prefetch_stage #(.XLEN(64), .DEPTH(4), .IMEM_WORDS(64), .RESET_PC(64'h0)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .PC(pc), .pc_if_id(pc_if_id),
        .instruction_if_id(instr), .valid_if_id(valid), .inv_fetch_addr(inv),
        .misaligned_redirect(mis), .flush_count(fcnt), .stall_count(scnt)
    );

    if_prefetch_stage #(.XLEN(64), .DEPTH(4), .IMEM_WORDS(4), .RESET_PC(64'h0)) dut4 (
        .clock(clock), .reset(rst4), .stall(stall4), .redirect(redirect4),
        .redirect_pc(redirect_pc4), .PC(pc4), .pc_if_id(pc_if_id4),
        .instruction_if_id(instr4), .valid_if_id(valid4), .inv_fetch_addr(inv4),
        .misaligned_redirect(mis4), .flush_count(fcnt4), .stall_count(scnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [63:0] rpc;
        logic [63:0] exp_pc;
        logic [63:0] exp_pcid;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [63:0] exp_pc;
        logic [63:0] exp_pcid;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_inv;
    } vec4_t;

    vec_t  vt [22];
    vec4_t v4 [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " PC"},       pc,        64'h0);
        chk({tag, " pc_if_id"}, pc_if_id,  64'h0);
        chk({tag, " instr"},    64'(instr), 64'(NOP));
        chk({tag, " valid"},    64'(valid), 64'h0);
        chk({tag, " inv"},      64'(inv),   64'h0);
        chk({tag, " mis"},      64'(mis),   64'h0);
        chk({tag, " fcnt"},     64'(fcnt),  64'h0);
        chk({tag, " scnt"},     64'(scnt),  64'h0);
    endtask

    initial begin
        logic [15:0] exp_f;
        logic [15:0] exp_s;

        //      stall red  rpc       pc        pc_if_id  instr valid mis
        vt[0]  = '{1'b0, 1'b0, 64'h0,  64'h04, 64'h00, NOP, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 64'h0,  64'h08, 64'h00, M0,  1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 64'h0,  64'h0C, 64'h04, M4,  1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 64'h0,  64'h10, 64'h04, M4,  1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 64'h0,  64'h14, 64'h04, M4,  1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 64'h0,  64'h18, 64'h04, M4,  1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 64'h0,  64'h18, 64'h04, M4,  1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 64'h0,  64'h1C, 64'h08, M8,  1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 64'h0,  64'h20, 64'h0C, MC,  1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 64'h40, 64'h40, 64'h0C, NOP, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 64'h0,  64'h44, 64'h0C, NOP, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 64'h0,  64'h48, 64'h0C, NOP, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 64'h0,  64'h4C, 64'h0C, NOP, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 64'h20, 64'h20, 64'h0C, NOP, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b0, 64'h0,  64'h24, 64'h0C, NOP, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b0, 64'h0,  64'h28, 64'h20, M20, 1'b1, 1'b0};
        vt[16] = '{1'b1, 1'b1, 64'h32, 64'h30, 64'h20, NOP, 1'b0, 1'b1};
        vt[17] = '{1'b0, 1'b0, 64'h0,  64'h34, 64'h20, NOP, 1'b0, 1'b1};
        vt[18] = '{1'b0, 1'b0, 64'h0,  64'h38, 64'h30, M30, 1'b1, 1'b1};
        vt[19] = '{1'b0, 1'b1, 64'h08, 64'h08, 64'h30, NOP, 1'b0, 1'b1};
        vt[20] = '{1'b0, 1'b0, 64'h0,  64'h0C, 64'h30, NOP, 1'b0, 1'b1};
        vt[21] = '{1'b0, 1'b0, 64'h0,  64'h10, 64'h08, M8,  1'b1, 1'b1};

        //      pc      pc_if_id instr valid inv
        v4[0] = '{64'h04, 64'h00, NOP, 1'b0, 1'b0};
        v4[1] = '{64'h08, 64'h00, M0,  1'b1, 1'b0};
        v4[2] = '{64'h0C, 64'h04, M4,  1'b1, 1'b0};
        v4[3] = '{64'h10, 64'h08, M8,  1'b1, 1'b1};
        v4[4] = '{64'h10, 64'h0C, MC,  1'b1, 1'b1};
        v4[5] = '{64'h10, 64'h0C, NOP, 1'b0, 1'b1};
        v4[6] = '{64'h10, 64'h0C, NOP, 1'b0, 1'b1};

        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst4 = 1'b0; stall4 = 1'b0; redirect4 = 1'b0; redirect_pc4 = '0;

        for (int i = 0; i < 64; i++) dut.instr_mem[i] = 32'h1000_0000 | 32'(i);
        dut.instr_mem[0] = M0;  dut.instr_mem[1] = M4;
        dut.instr_mem[2] = M8;  dut.instr_mem[3] = MC;
        dut4.instr_mem[0] = M0; dut4.instr_mem[1] = M4;
        dut4.instr_mem[2] = M8; dut4.instr_mem[3] = MC;

        #12;
        chk_reset_state("reset");
        reset = 1'b1;

        // Main fetch / stall / redirect sequence.
        for (int i = 0; i < 22; i++) begin
            stall       = vt[i].stall;
            redirect    = vt[i].redirect;
            redirect_pc = vt[i].rpc;
            @(posedge clock); #1;
            chk($sformatf("v%0d PC", i),       pc,               vt[i].exp_pc);
            chk($sformatf("v%0d pc_if_id", i), pc_if_id,         vt[i].exp_pcid);
            chk($sformatf("v%0d instr", i),    64'(instr),       64'(vt[i].exp_instr));
            chk($sformatf("v%0d valid", i),    64'(valid),       64'(vt[i].exp_valid));
            chk($sformatf("v%0d mis", i),      64'(mis),         64'(vt[i].exp_mis));
            chk($sformatf("v%0d inv", i),      64'(inv),         64'h0);
        end
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

`ifdef IF_PREFETCH_PERF_EN
        exp_f = 16'd4;
        exp_s = 16'd7;
`else
        exp_f = 16'd0;
        exp_s = 16'd0;
`endif
        chk("flush_count", 64'(fcnt), 64'(exp_f));
        chk("stall_count", 64'(scnt), 64'(exp_s));

        // Asynchronous reset mid-stream: outputs return before any clock edge.
        #3 reset = 1'b0;
        #1;
        chk_reset_state("async reset");
        #2 reset = 1'b1;
        @(posedge clock); #1;
        chk("post-reset e1 valid", 64'(valid), 64'h0);
        chk("post-reset e1 PC",    pc,         64'h4);
        @(posedge clock); #1;
        chk("post-reset e2 valid", 64'(valid), 64'h1);
        chk("post-reset e2 pcid",  pc_if_id,   64'h0);
        chk("post-reset e2 instr", 64'(instr), 64'(M0));

        // Out-of-range fetch on the 4-word instance.
        chk("imem4 reset inv", 64'(inv4), 64'h0);
        chk("imem4 reset PC",  pc4,       64'h0);
        rst4 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #1;
            chk($sformatf("m4_%0d PC", i),       pc4,          v4[i].exp_pc);
            chk($sformatf("m4_%0d pc_if_id", i), pc_if_id4,    v4[i].exp_pcid);
            chk($sformatf("m4_%0d instr", i),    64'(instr4),  64'(v4[i].exp_instr));
            chk($sformatf("m4_%0d valid", i),    64'(valid4),  64'(v4[i].exp_valid));
            chk($sformatf("m4_%0d inv", i),      64'(inv4),    64'(v4[i].exp_inv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
